pixel_renderer: RTL and testbench



---
 rtl/pixel_renderer.sv | 217 +++++++++++++++++++++
 tb/tb_pixel_renderer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_renderer.sv
// Two-stage per-pixel colour generator with frame-level collision accumulation.
// Game state is shadowed on frame_start so a whole frame renders from one snapshot.
module pixel_renderer #(
  parameter int PIXELS_VISIBLE = 640,
  parameter int ROWS_VISIBLE   = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_WIDTH   = 64,
  parameter int PADDLE_HEIGHT  = 8,
  parameter int PADDLE_ROW     = 456,
  parameter int BRICK_COLS     = 10,
  parameter int BRICK_ROWS     = 6,
  parameter int BRICK_WIDTH    = 64,
  parameter int BRICK_HEIGHT   = 16,
  parameter int BRICK_TOP      = 48
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [9:0]                                pixel_x,
  input  logic [9:0]                                pixel_y,
  input  logic                                      visible,
  input  logic                                      frame_start,
  input  logic [9:0]                                ball_x,
  input  logic [9:0]                                ball_y,
  input  logic [9:0]                                paddle_x,
  input  logic [BRICK_ROWS*BRICK_COLS-1:0]          bricks,
  output logic [3:0]                                vga_red,
  output logic [3:0]                                vga_green,
  output logic [3:0]                                vga_blue,
  output logic                                      collision_valid,
  output logic                                      collision_paddle,
  output logic                                      collision_brick,
  output logic                                      collision_side,
  output logic                                      collision_top,
  output logic                                      collision_floor,
  output logic [$clog2(BRICK_ROWS*BRICK_COLS)-1:0]  collision_brick_index,
  output logic                                      collision_overrun,
  input  logic                                      collision_ack
);

  localparam int NUM_BRICKS = BRICK_ROWS * BRICK_COLS;
  localparam int IDX_W      = $clog2(NUM_BRICKS);
  localparam int ROW_W      = $clog2(BRICK_ROWS);
  localparam int COL_SHIFT  = $clog2(BRICK_WIDTH);
  localparam int ROW_SHIFT  = $clog2(BRICK_HEIGHT);

  localparam logic [10:0] BALL_M1     = 11'(BALL_SIZE - 1);
  localparam logic [10:0] PAD_W_M1    = 11'(PADDLE_WIDTH - 1);
  localparam logic [10:0] PAD_TOP     = 11'(PADDLE_ROW);
  localparam logic [10:0] PAD_BOT     = 11'(PADDLE_ROW + PADDLE_HEIGHT - 1);
  localparam logic [10:0] FIELD_TOP   = 11'(BRICK_TOP);
  localparam logic [10:0] FIELD_ROWS  = 11'(BRICK_ROWS);
  localparam logic [10:0] FIELD_COLS  = 11'(BRICK_COLS);
  localparam logic [10:0] X_LAST      = 11'(PIXELS_VISIBLE - 1);
  localparam logic [10:0] Y_LAST      = 11'(ROWS_VISIBLE - 1);
  localparam logic [ROW_W-1:0] RED_ROWS    = ROW_W'(2);
  localparam logic [ROW_W-1:0] YELLOW_ROWS = ROW_W'(4);

  typedef struct packed {
    logic              vis;
    logic              ball;
    logic              paddle;
    logic              brick;
    logic              side;
    logic              top;
    logic              floor;
    logic [ROW_W-1:0]  row;
    logic [IDX_W-1:0]  idx;
  } stage1_t;

  typedef struct packed {
    logic paddle;
    logic brick;
    logic side;
    logic top;
    logic floor;
  } flags_t;

  logic [9:0]            ball_x_q, ball_x_d;
  logic [9:0]            ball_y_q, ball_y_d;
  logic [9:0]            paddle_x_q, paddle_x_d;
  logic [NUM_BRICKS-1:0] bricks_q, bricks_d;
  stage1_t               s1_q, s1_d;
  logic [11:0]           rgb_q, rgb_d;
  flags_t                acc_q, acc_d;
  logic [IDX_W-1:0]      acc_idx_q, acc_idx_d;
  flags_t                rep_q, rep_d;
  logic [IDX_W-1:0]      rep_idx_q, rep_idx_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  logic [10:0] x, y, bx, by, px, y_rel, col, row, idx_full;
  logic        in_field, mortar, ball_px;
  flags_t      contrib, merged;

  // Stage 1: geometry tests against the shadowed game state.
  always_comb begin
    x        = {1'b0, pixel_x};
    y        = {1'b0, pixel_y};
    bx       = {1'b0, ball_x_q};
    by       = {1'b0, ball_y_q};
    px       = {1'b0, paddle_x_q};
    y_rel    = y - FIELD_TOP;
    col      = x >> COL_SHIFT;
    row      = y_rel >> ROW_SHIFT;
    idx_full = row * FIELD_COLS + col;
    in_field = (y >= FIELD_TOP) && (row < FIELD_ROWS) && (col < FIELD_COLS);
    mortar   = (x[COL_SHIFT-1:0] == '0) || (y_rel[ROW_SHIFT-1:0] == '0);

    s1_d        = '0;
    s1_d.vis    = visible;
    s1_d.ball   = (x >= bx) && (x <= bx + BALL_M1) && (y >= by) && (y <= by + BALL_M1);
    s1_d.paddle = (x >= px) && (x <= px + PAD_W_M1) && (y >= PAD_TOP) && (y <= PAD_BOT);
    s1_d.brick  = in_field && !mortar && bricks_q[idx_full[IDX_W-1:0]];
    s1_d.row    = row[ROW_W-1:0];
    s1_d.idx    = idx_full[IDX_W-1:0];
    s1_d.side   = (x == '0) || (x == X_LAST);
    s1_d.top    = (y == '0);
    s1_d.floor  = (y == Y_LAST);
  end

  // Stage 2: colour by priority ball > paddle > brick > background.
  always_comb begin
    rgb_d = 12'h000;
    if (s1_q.vis) begin
      if (s1_q.ball)                 rgb_d = 12'hFFF;
      else if (s1_q.paddle)          rgb_d = 12'h0FF;
      else if (s1_q.brick) begin
        if (s1_q.row < RED_ROWS)         rgb_d = 12'hF00;
        else if (s1_q.row < YELLOW_ROWS) rgb_d = 12'hFF0;
        else                             rgb_d = 12'h0F0;
      end
    end
  end

  // Accumulate, publish and handshake. The pixel sitting in stage 1 during
  // frame_start is folded into the report so no hit is lost at the boundary.
  always_comb begin
    ball_px = s1_q.vis && s1_q.ball;
    contrib = ball_px ? flags_t'{s1_q.paddle, s1_q.brick, s1_q.side, s1_q.top, s1_q.floor}
                      : '0;
    merged  = acc_q | contrib;

    acc_d     = merged;
    acc_idx_d = (!acc_q.brick && contrib.brick) ? s1_q.idx : acc_idx_q;
    rep_d     = rep_q;
    rep_idx_d = rep_idx_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (frame_start && (merged != '0)) begin
      rep_d     = merged;
      rep_idx_d = acc_idx_d;
      valid_d   = 1'b1;
      overrun_d = valid_q && !collision_ack;
    end else if (collision_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (frame_start) begin
      acc_d     = '0;
      acc_idx_d = '0;
    end
  end

  always_comb begin
    ball_x_d   = frame_start ? ball_x   : ball_x_q;
    ball_y_d   = frame_start ? ball_y   : ball_y_q;
    paddle_x_d = frame_start ? paddle_x : paddle_x_q;
    bricks_d   = frame_start ? bricks   : bricks_q;
  end

  // NOTE: the shadows are reset along with the pipeline so the first frame
  // after reset renders an empty field instead of whatever the flops woke up as.
  always_ff @(posedge clock) begin
    if (reset) begin
      ball_x_q   <= '0;
      ball_y_q   <= '0;
      paddle_x_q <= '0;
      bricks_q   <= '0;
      s1_q       <= '0;
      rgb_q      <= '0;
      acc_q      <= '0;
      acc_idx_q  <= '0;
      rep_q      <= '0;
      rep_idx_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      paddle_x_q <= paddle_x_d;
      bricks_q   <= bricks_d;
      s1_q       <= s1_d;
      rgb_q      <= rgb_d;
      acc_q      <= acc_d;
      acc_idx_q  <= acc_idx_d;
      rep_q      <= rep_d;
      rep_idx_q  <= rep_idx_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign vga_red               = rgb_q[11:8];
  assign vga_green             = rgb_q[7:4];
  assign vga_blue              = rgb_q[3:0];
  assign collision_valid       = valid_q;
  assign collision_paddle      = rep_q.paddle;
  assign collision_brick       = rep_q.brick;
  assign collision_side        = rep_q.side;
  assign collision_top         = rep_q.top;
  assign collision_floor       = rep_q.floor;
  assign collision_brick_index = rep_idx_q;
  assign collision_overrun     = overrun_q;

endmodule

// File: tb/tb_pixel_renderer.sv
// Directed bench for pixel_renderer: table of single-pixel colour vectors plus
// hand-written frame sequences for the collision report and its handshake.
module tb_pixel_renderer;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y, ball_x, ball_y, paddle_x;
  logic        visible, frame_start, collision_ack;
  logic [59:0] bricks;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic        collision_valid, collision_paddle, collision_brick;
  logic        collision_side, collision_top, collision_floor, collision_overrun;
  logic [5:0]  collision_brick_index;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  pixel_renderer dut (
    .clock                 (clock),
    .reset                 (reset),
    .pixel_x               (pixel_x),
    .pixel_y               (pixel_y),
    .visible               (visible),
    .frame_start           (frame_start),
    .ball_x                (ball_x),
    .ball_y                (ball_y),
    .paddle_x              (paddle_x),
    .bricks                (bricks),
    .vga_red               (vga_red),
    .vga_green             (vga_green),
    .vga_blue              (vga_blue),
    .collision_valid       (collision_valid),
    .collision_paddle      (collision_paddle),
    .collision_brick       (collision_brick),
    .collision_side        (collision_side),
    .collision_top         (collision_top),
    .collision_floor       (collision_floor),
    .collision_brick_index (collision_brick_index),
    .collision_overrun     (collision_overrun),
    .collision_ack         (collision_ack)
  );

  typedef struct {
    string       name;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vis;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic present(input int x, input int y, input logic v);
    @(negedge clock);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    visible = v;
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    visible = 1'b0;
    repeat (n) @(posedge clock);
  endtask

  task automatic scan(input int x0, input int y0, input int w, input int h);
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++)
        present(xx, yy, 1'b1);
    idle(2);
  endtask

  task automatic frame_pulse(input logic ack);
    @(negedge clock);
    visible       = 1'b0;
    frame_start   = 1'b1;
    collision_ack = ack;
    @(posedge clock);
    #1;
    frame_start   = 1'b0;
    collision_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clock);
    collision_ack = 1'b1;
    @(posedge clock);
    #1;
    collision_ack = 1'b0;
  endtask

  task automatic check_report(input string tag, input logic v, input logic p, input logic b,
                              input logic s, input logic t, input logic f, input logic o);
    check({tag, "_valid"},   32'(collision_valid),   32'(v));
    check({tag, "_paddle"},  32'(collision_paddle),  32'(p));
    check({tag, "_brick"},   32'(collision_brick),   32'(b));
    check({tag, "_side"},    32'(collision_side),    32'(s));
    check({tag, "_top"},     32'(collision_top),     32'(t));
    check({tag, "_floor"},   32'(collision_floor),   32'(f));
    check({tag, "_overrun"}, 32'(collision_overrun), 32'(o));
  endtask

  function automatic logic [11:0] rgb();
    return {vga_red, vga_green, vga_blue};
  endfunction

  initial begin
    vecs[0]  = '{"paddle_in",         10'd120, 10'd460, 1'b1, 12'h0FF};
    vecs[1]  = '{"paddle_left_out",   10'd99,  10'd460, 1'b1, 12'h000};
    vecs[2]  = '{"paddle_invisible",  10'd120, 10'd460, 1'b0, 12'h000};
    vecs[3]  = '{"paddle_right_edge", 10'd163, 10'd463, 1'b1, 12'h0FF};
    vecs[4]  = '{"paddle_right_out",  10'd164, 10'd463, 1'b1, 12'h000};
    vecs[5]  = '{"paddle_below",      10'd120, 10'd464, 1'b1, 12'h000};
    vecs[6]  = '{"brick13",           10'd200, 10'd70,  1'b1, 12'hF00};
    vecs[7]  = '{"mortar_x",          10'd192, 10'd70,  1'b1, 12'h000};
    vecs[8]  = '{"mortar_y",          10'd200, 10'd64,  1'b1, 12'h000};
    vecs[9]  = '{"brick_absent",      10'd163, 10'd60,  1'b1, 12'h000};
    vecs[10] = '{"above_field",       10'd200, 10'd47,  1'b1, 12'h000};
    vecs[11] = '{"brick_row2",        10'd10,  10'd90,  1'b1, 12'hFF0};
    vecs[12] = '{"brick_row4",        10'd10,  10'd122, 1'b1, 12'h0F0};
    vecs[13] = '{"brick_row5_col9",   10'd600, 10'd135, 1'b1, 12'h0F0};
    vecs[14] = '{"below_field",       10'd10,  10'd150, 1'b1, 12'h000};
    vecs[15] = '{"ball_corner",       10'd300, 10'd300, 1'b1, 12'hFFF};
    vecs[16] = '{"ball_far_corner",   10'd307, 10'd307, 1'b1, 12'hFFF};
    vecs[17] = '{"ball_right_out",    10'd308, 10'd300, 1'b1, 12'h000};

    reset = 1'b1; pixel_x = '0; pixel_y = '0; visible = 1'b0; frame_start = 1'b0;
    ball_x = '0; ball_y = '0; paddle_x = '0; bricks = '0; collision_ack = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;

    // Ball shadow is (0,0) after reset: these pixels would accumulate side/top.
    present(0, 0, 1'b1);
    present(1, 0, 1'b1);
    @(negedge clock); visible = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    check("reset_rgb_edge1", 32'(rgb()), 32'h000);
    check("reset_valid", 32'(collision_valid), 32'd0);
    check("reset_overrun", 32'(collision_overrun), 32'd0);
    @(posedge clock); #1;
    check("reset_rgb_edge2", 32'(rgb()), 32'h000);
    check("reset_index", 32'(collision_brick_index), 32'd0);
    @(negedge clock); reset = 1'b0;
    idle(2);
    frame_pulse(1'b0);
    check("no_hits_after_reset_valid", 32'(collision_valid), 32'd0);

    // Single-pixel colour table.
    ball_x = 10'd300; ball_y = 10'd300; paddle_x = 10'd100;
    bricks = '0; bricks[13] = 1'b1; bricks[20] = 1'b1; bricks[40] = 1'b1; bricks[59] = 1'b1;
    frame_pulse(1'b0);
    for (int i = 0; i < 18; i++) begin
      present(int'(vecs[i].x), int'(vecs[i].y), vecs[i].vis);
      @(posedge clock); @(posedge clock); #1;
      check(vecs[i].name, 32'(rgb()), 32'(vecs[i].rgb));
    end
    idle(2);

    // Cleared brick bit renders background; ball-only hits raise no report.
    bricks = '0;
    frame_pulse(1'b0);
    check("ball_only_no_report", 32'(collision_valid), 32'd0);
    present(200, 70, 1'b1);
    @(posedge clock); @(posedge clock); #1;
    check("brick13_cleared", 32'(rgb()), 32'h000);
    idle(2);

    // Brick collision report, held until ack.
    bricks = '0; bricks[13] = 1'b1; ball_x = 10'd200; ball_y = 10'd66;
    frame_pulse(1'b0);
    scan(196, 62, 16, 16);
    ball_x = 10'd0; ball_y = 10'd200;
    frame_pulse(1'b0);
    check_report("brick_rep", 1, 0, 1, 0, 0, 0, 0);
    check("brick_rep_index", 32'(collision_brick_index), 32'd13);
    idle(5); #1;
    check("brick_rep_held", 32'(collision_valid), 32'd1);
    ack_pulse();
    check("brick_ack_valid", 32'(collision_valid), 32'd0);
    check("brick_ack_flag_holds", 32'(collision_brick), 32'd1);

    // Side wall: first report clean, second overruns, third coincides with ack.
    scan(0, 198, 12, 12);
    frame_pulse(1'b0);
    check_report("side_rep1", 1, 0, 0, 1, 0, 0, 0);
    scan(0, 198, 12, 12);
    frame_pulse(1'b0);
    check_report("side_rep2", 1, 0, 0, 1, 0, 0, 1);
    scan(0, 198, 12, 12);
    frame_pulse(1'b1);
    check_report("side_rep3_ack", 1, 0, 0, 1, 0, 0, 0);
    ack_pulse();
    check("side_ack_valid", 32'(collision_valid), 32'd0);
    check("side_ack_overrun", 32'(collision_overrun), 32'd0);
    ack_pulse();
    check("ack_while_idle", 32'(collision_valid), 32'd0);

    // Ball straddling bricks 13 and 14: index is the first hit in raster order.
    bricks = '0; bricks[13] = 1'b1; bricks[14] = 1'b1; ball_x = 10'd252; ball_y = 10'd66;
    frame_pulse(1'b0);
    scan(250, 64, 12, 12);
    ball_x = 10'd632; ball_y = 10'd472;
    frame_pulse(1'b0);
    check_report("straddle_rep", 1, 0, 1, 0, 0, 0, 0);
    check("straddle_index", 32'(collision_brick_index), 32'd13);
    ack_pulse();

    // Bottom-right corner: right wall and floor.
    scan(628, 468, 12, 12);
    frame_pulse(1'b0);
    check_report("corner_rep", 1, 0, 0, 1, 0, 1, 0);
    ack_pulse();

    // Ball over paddle.
    ball_x = 10'd110; ball_y = 10'd452; paddle_x = 10'd100;
    frame_pulse(1'b0);
    check("pre_paddle_valid", 32'(collision_valid), 32'd0);
    present(112, 458, 1'b1);
    @(posedge clock); @(posedge clock); #1;
    check("ball_over_paddle_rgb", 32'(rgb()), 32'hFFF);
    scan(108, 450, 12, 12);
    frame_pulse(1'b0);
    check_report("paddle_rep", 1, 1, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
